// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the Stein GCD engine.
// State encoding, cycle-counter width and the k-register width helper.
package gcd_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_REDUCE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        REDUCE = ST_REDUCE,
        DONE   = ST_DONE
    } gcd_state_t;

    // Width of the optional busy-cycle counter and its latched copy.
    localparam int CYCLE_CNT_W = 16;

    // k counts common factors of two; it never exceeds width-1.
    function automatic int k_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/gcd_step.sv
// gcd_step: one combinational Stein iteration.
// SHIFT phase strips common factors of two; any other phase performs one
// reduction step. finish flags that one operand has reached zero.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  gcd_state_t       phase,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next,
    output logic             k_inc,
    output logic             finish
);

    // Single step: zero check first, then phase-specific shift or subtract.
    always_comb begin
        a_next = a;
        b_next = b;
        k_inc  = 1'b0;
        finish = 1'b0;
        if (a == '0 || b == '0) begin
            finish = 1'b1;
        end else if (phase == SHIFT) begin
            if (!a[0] && !b[0]) begin
                a_next = a >> 1;
                b_next = b >> 1;
                k_inc  = 1'b1;
            end
        end else begin
            if (!a[0]) begin
                a_next = a >> 1;
            end else if (!b[0]) begin
                b_next = b >> 1;
            end else if (a >= b) begin
                a_next = a - b;
            end else begin
                b_next = b - a;
            end
        end
    end

endmodule

// File: rtl/gcd_stein.sv
// gcd_stein: iterative binary (Stein) GCD engine, one step per clock.
// Optional feature: define GCD_CYCLE_COUNT_EN to add the 16-bit busy-cycle
// counter and the cycles_o port.
module gcd_stein
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             calculate_new,
    output logic [WIDTH-1:0] out,
    output logic             data_en,
    output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [CYCLE_CNT_W-1:0] cycles_o
`endif
);

    localparam int KW = k_width(WIDTH);

    gcd_state_t       state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next;
    logic [KW-1:0]    k_reg, k_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic             data_en_reg, busy_reg;

    logic [WIDTH-1:0] a_step, b_step;
    logic             step_k_inc, step_finish;
    logic [WIDTH-1:0] result;

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_reg),
        .b      (b_reg),
        .phase  (state_reg),
        .a_next (a_step),
        .b_next (b_step),
        .k_inc  (step_k_inc),
        .finish (step_finish)
    );

    // When one operand is zero the other (or zero) holds the odd part.
    assign result = (a_reg | b_reg) << k_reg;

    // Next-state and datapath load selection.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        k_next     = k_reg;
        out_next   = out_reg;
        case (state_reg)
            IDLE: begin
                if (calculate_new) begin
                    a_next     = x_i;
                    b_next     = y_i;
                    k_next     = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (step_finish) begin
                    out_next   = result;
                    state_next = DONE;
                end else if (step_k_inc) begin
                    a_next = a_step;
                    b_next = b_step;
                    k_next = k_reg + KW'(1);
                end else begin
                    state_next = REDUCE;
                end
            end
            REDUCE: begin
                if (step_finish) begin
                    out_next   = result;
                    state_next = DONE;
                end else begin
                    a_next = a_step;
                    b_next = b_step;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, operand and output registers; strobes decoded from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            k_reg       <= '0;
            out_reg     <= '0;
            data_en_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            k_reg       <= k_next;
            out_reg     <= out_next;
            data_en_reg <= (state_next == DONE);
            busy_reg    <= (state_next != IDLE);
        end
    end

    assign out     = out_reg;
    assign data_en = data_en_reg;
    assign busy    = busy_reg;

`ifdef GCD_CYCLE_COUNT_EN
    logic [CYCLE_CNT_W-1:0] cnt_reg, cnt_next, cycles_reg;

    // Busy-cycle counter: clears on accept, saturates at all-ones.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == IDLE && calculate_new) begin
            cnt_next = '0;
        end else if (busy_reg && cnt_reg != '1) begin
            cnt_next = cnt_reg + CYCLE_CNT_W'(1);
        end
    end

    // Counter register and latched count captured as DONE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            cycles_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            if (state_next == DONE) begin
                cycles_reg <= cnt_next;
            end
        end
    end

    assign cycles_o = cycles_reg;
`endif

endmodule

// File: tb/tb_gcd_stein.sv
// tb_gcd_stein: directed and random checks of gcd_stein at WIDTH 8, 16, 32.
// A Euclid reference model plus literal expectations; one negedge checker.
module tb_gcd_stein;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        calc  [NDUT];
    logic [31:0] x_w   [NDUT];
    logic [31:0] y_w   [NDUT];
    logic [31:0] out_w [NDUT];
    logic        den_w [NDUT];
    logic        busy_w[NDUT];
    logic [15:0] cyc_w [NDUT];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int W = 8 << gi;
            logic [W-1:0] o;
`ifdef GCD_CYCLE_COUNT_EN
            logic [15:0] c;
`endif
            gcd_stein #(.WIDTH(W)) u_dut (
                .clk           (clk),
                .rst           (rst),
                .x_i           (x_w[gi][W-1:0]),
                .y_i           (y_w[gi][W-1:0]),
                .calculate_new (calc[gi]),
                .out           (o),
                .data_en       (den_w[gi]),
                .busy          (busy_w[gi])
`ifdef GCD_CYCLE_COUNT_EN
                ,
                .cycles_o      (c)
`endif
            );
            assign out_w[gi] = 32'(o);
`ifdef GCD_CYCLE_COUNT_EN
            assign cyc_w[gi] = c;
`else
            assign cyc_w[gi] = '0;
`endif
        end
    endgenerate

    // Hand-computed results, in completion order per DUT (-1 latency = any).
    int lit_n   [NDUT]    = '{1, 1, 8};
    int lit_val [NDUT][8] = '{'{64, 0, 0, 0, 0, 0, 0, 0},
                              '{1, 0, 0, 0, 0, 0, 0, 0},
                              '{5, 6, 42, 0, 1, 250, 7, 7}};
    int lit_lat [NDUT][8] = '{'{-1, -1, -1, -1, -1, -1, -1, -1},
                              '{-1, -1, -1, -1, -1, -1, -1, -1},
                              '{-1, -1, 1, 1, -1, -1, -1, 3}};

    // Model state, written only by the checker process.
    bit          pend     [NDUT] = '{default: 1'b0};
    int          age      [NDUT] = '{default: 0};
    int          lit_idx  [NDUT] = '{default: 0};
    logic [31:0] exp_val  [NDUT] = '{default: 32'd0};
    logic [31:0] last_out [NDUT] = '{default: 32'd0};
    logic [15:0] last_cyc [NDUT] = '{default: 16'd0};
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [31:0] width_mask(input int i);
        return (i == 2) ? 32'hFFFF_FFFF : ((32'd1 << (8 << i)) - 32'd1);
    endfunction

    task automatic check(input bit ok, input string name, input int i,
                         input longint act, input longint req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s dut%0d (width %0d): got %0h, required %0h at %0t",
                     name, i, 8 << i, act, req, $time);
        end
    endtask

    // Per-cycle checker and reference model, sampled away from the rising edge.
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            int bound;
            int lat;
            bit fin;
            bound = 5 * (8 << i) + 4;
            fin   = 1'b0;
            if (pend[i]) age[i]++;
            lat = age[i] - 1;
            if (den_w[i] === 1'b1) begin
                check(pend[i], "unexpected_data_en", i, 1, 0);
                if (pend[i]) begin
                    check(out_w[i] === exp_val[i], "out_vs_model", i, out_w[i], exp_val[i]);
                    check(lat <= bound, "latency_bound", i, lat, bound);
                    check(busy_w[i] === 1'b1, "busy_in_done", i, busy_w[i], 1);
`ifdef GCD_CYCLE_COUNT_EN
                    check(cyc_w[i] === 16'(lat), "cycles_o", i, cyc_w[i], lat);
                    last_cyc[i] = 16'(lat);
`endif
                    if (lit_idx[i] < lit_n[i]) begin
                        check(out_w[i] === 32'(lit_val[i][lit_idx[i]]), "out_literal", i,
                              out_w[i], lit_val[i][lit_idx[i]]);
                        if (lit_lat[i][lit_idx[i]] >= 0)
                            check(lat == lit_lat[i][lit_idx[i]], "latency_literal", i,
                                  lat, lit_lat[i][lit_idx[i]]);
                        lit_idx[i]++;
                    end
                    last_out[i] = exp_val[i];
                    pend[i]     = 1'b0;
                    fin         = 1'b1;
                end
            end else begin
                check(out_w[i] === last_out[i], "out_hold", i, out_w[i], last_out[i]);
                check(busy_w[i] === pend[i], "busy", i, busy_w[i], pend[i]);
                check(den_w[i] === 1'b0, "data_en_level", i, den_w[i], 0);
`ifdef GCD_CYCLE_COUNT_EN
                check(cyc_w[i] === last_cyc[i], "cycles_hold", i, cyc_w[i], last_cyc[i]);
`endif
                if (pend[i] && lat > bound) begin
                    check(1'b0, "timeout", i, lat, bound);
                    pend[i] = 1'b0;
                end
            end
            // Effect of the upcoming rising edge.
            if (rst) begin
                pend[i]     = 1'b0;
                last_out[i] = '0;
                last_cyc[i] = '0;
            end else if (calc[i] && !pend[i] && !fin) begin
                exp_val[i] = gcd_ref(x_w[i] & width_mask(i), y_w[i] & width_mask(i));
                pend[i]    = 1'b1;
                age[i]     = 0;
            end
        end
    end

    task automatic start(input int i, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #2;
        x_w[i]  = x;
        y_w[i]  = y;
        calc[i] = 1'b1;
        @(posedge clk); #2;
        calc[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        for (int c = 0; c < 1000 && pend[i]; c++) @(posedge clk);
        if (pend[i]) begin
            $display("FAIL wait_idle dut%0d: still pending, required idle", i);
            $fatal(1, "bench stalled");
        end
    endtask

    task automatic run(input int i, input logic [31:0] x, input logic [31:0] y);
        start(i, x, y);
        wait_idle(i);
    endtask

    // Directed vectors, then random operands per width.
    initial begin
        logic [31:0] rx, ry;
        for (int i = 0; i < NDUT; i++) begin
            calc[i] = 1'b0;
            x_w[i]  = '0;
            y_w[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        run(2, 32'd95, 32'd25);
        run(2, 32'd48, 32'd18);
        run(2, 32'd0, 32'd42);
        run(2, 32'd0, 32'd0);
        run(2, 32'hFFFF_FFFF, 32'h8000_0000);

        // Second request while busy must be ignored.
        start(2, 32'd1000, 32'd750);
        repeat (2) @(posedge clk);
        #2;
        x_w[2]  = 32'd9;
        y_w[2]  = 32'd3;
        calc[2] = 1'b1;
        @(posedge clk); #2;
        calc[2] = 1'b0;
        wait_idle(2);

        // Reset mid-computation abandons the result.
        start(2, 32'd12345, 32'd54321);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        wait_idle(2);
        repeat (3) @(posedge clk);

        run(2, 32'd14, 32'd21);
        run(2, 32'd7, 32'd7);
        run(0, 32'd128, 32'd192);
        run(1, 32'hFFFF, 32'h8000);

        for (int i = 0; i < NDUT; i++) begin
            for (int n = 0; n < 25; n++) begin
                rx = $urandom() & width_mask(i);
                ry = $urandom() & width_mask(i);
                if ($urandom_range(0, 7) == 0) rx = '0;
                if ($urandom_range(0, 7) == 0) ry = '0;
                run(i, rx, ry);
            end
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
